// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side request bus and memory-side line bus of the data cache.
//
// Handshake semantics, both sides:
//   - The requester raises a strobe (d_readC / d_writeC, mem_read / mem_write) and
//     holds it, with its address/data stable, until the responder completes it.
//   - The responder completes it with a single-cycle pulse (d_ready / mem_ack).
//     Data returned by the responder (d_data_r / mem_data_r) is only meaningful
//     in that completion cycle.
//
// Modports:
//   slave  - the cache controller (responds to the CPU, drives memory strobes)
//   master - the environment (CPU MEM stage plus main memory)
//
// Signals:
//   d_readC, d_writeC   CPU load/store request
//   d_address           word address
//   d_data_w / d_data_r store data / load data
//   d_ready             request complete this cycle
//   mem_read, mem_write line fill / single-word write strobes
//   mem_address         fill line base or write word address
//   mem_data_w          write data
//   mem_data_r          fill line, word 0 in [15:0]
//   mem_ack             memory completion pulse
interface dcache_ctrl_if;
  logic        d_readC;
  logic        d_writeC;
  logic [15:0] d_address;
  logic [15:0] d_data_w;
  logic [15:0] d_data_r;
  logic        d_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_data_w;
  logic [63:0] mem_data_r;
  logic        mem_ack;

  modport slave (
    input  d_readC, d_writeC, d_address, d_data_w, mem_data_r, mem_ack,
    output d_data_r, d_ready, mem_read, mem_write, mem_address, mem_data_w
  );

  modport master (
    output d_readC, d_writeC, d_address, d_data_w, mem_data_r, mem_ack,
    input  d_data_r, d_ready, mem_read, mem_write, mem_address, mem_data_w
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between the MEM stage and main memory.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset_n    asynchronous active-low reset; clears state and all valid bits
//   bus        dcache_ctrl_if.slave (CPU request side and memory side)
//   dbg_state  current FSM state (IDLE=0, FILL=1, WRITE=2, RESP=3)
//   hit_count, access_count  statistics, present only with DCACHE_STATS_EN
//
// Parameters:
//   INDEX_BITS  line index width; 2^INDEX_BITS lines of 4 x 16-bit words.
//
// Optional feature: define DCACHE_STATS_EN to add the hit/access counters.
//
// Read hits answer combinationally in IDLE. Read misses fill the whole line
// then answer from a latched word in RESP. Writes always go to memory and
// update the cached word only if the line is present when memory acknowledges.
module dcache_ctrl #(
  parameter int INDEX_BITS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  dcache_ctrl_if.slave      bus,
  output logic [1:0]        dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       access_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 14 - INDEX_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]          state;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [15:0]         data_mem [LINES][4];
  logic [1:0]          lat_off;
  logic [15:0]         resp_word;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [TAG_BITS-1:0]   lat_tag;
  logic                  req_hit;
  logic                  lat_hit;
  logic                  read_hit;
  logic                  fill_done;
  logic                  write_done;

  // Incoming request address decode.
  assign req_idx = bus.d_address[INDEX_BITS+1:2];
  assign req_tag = bus.d_address[15:INDEX_BITS+2];
  assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // mem_address doubles as the latched request address (offset cleared for fills).
  assign lat_idx = bus.mem_address[INDEX_BITS+1:2];
  assign lat_tag = bus.mem_address[15:INDEX_BITS+2];
  assign lat_hit = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  // A simultaneous write request wins, so a read hit only counts when no write is pending.
  assign read_hit   = (state == IDLE) && bus.d_readC && !bus.d_writeC && req_hit;
  assign fill_done  = (state == FILL) && bus.mem_ack;
  assign write_done = (state == WRITE) && bus.mem_ack;

  // Strobes decode straight from state so reset drops them asynchronously.
  assign bus.mem_read  = (state == FILL);
  assign bus.mem_write = (state == WRITE);
  assign bus.d_ready   = (state == RESP) || read_hit;
  assign dbg_state     = state;

  always_comb begin
    bus.d_data_r = '0;
    if (state == RESP) begin
      bus.d_data_r = resp_word;
    end else if (read_hit) begin
      bus.d_data_r = data_mem[req_idx][bus.d_address[1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      valid           <= '0;
      bus.mem_address <= '0;
      bus.mem_data_w  <= '0;
      lat_off         <= '0;
      resp_word       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_writeC) begin
            bus.mem_address <= bus.d_address;
            bus.mem_data_w  <= bus.d_data_w;
            resp_word       <= '0;
            state           <= WRITE;
          end else if (bus.d_readC && !req_hit) begin
            bus.mem_address <= {bus.d_address[15:2], 2'b00};
            lat_off         <= bus.d_address[1:0];
            state           <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            valid[lat_idx] <= 1'b1;
            resp_word      <= bus.mem_data_r[{lat_off, 4'b0000} +: 16];
            state          <= RESP;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[lat_idx] <= lat_tag;
      for (int w = 0; w < 4; w++) begin
        data_mem[lat_idx][w] <= bus.mem_data_r[16*w +: 16];
      end
    end else if (write_done && lat_hit) begin
      data_mem[lat_idx][bus.mem_address[1:0]] <= bus.mem_data_w;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      if (bus.d_ready) begin
        access_count <= access_count + 16'd1;
      end
      if (read_hit) begin
        hit_count <= hit_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl (INDEX_BITS=2).
// A behavioural memory answers fills and writes after a programmable latency;
// expected load data is queued when a read is issued and compared when d_ready
// arrives. A shadow tag table predicts hits for the randomised section.
`timescale 1ns/1ps
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] dbg_state;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] access_count;
`endif

  dcache_ctrl_if bus ();

  dcache_ctrl #(.INDEX_BITS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .access_count (access_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // Main memory model; unwritten words hold a pattern derived from the address.
  logic [15:0] mem_model [int];
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  // Shadow of the cache tag state: 4 lines, 12-bit tags.
  logic        sh_valid [4];
  logic [11:0] sh_tag   [4];
  int exp_acc  = 0;
  int exp_hits = 0;

  // ---------------- memory responder ----------------
  int          next_lat    = 2;
  int          wait_left   = -1;
  logic        inject_ack  = 1'b0;
  logic [15:0] last_addr   = '0;
  logic [15:0] last_wdata  = '0;
  int          fill_count  = 0;
  int          write_count = 0;

  initial begin
    bus.mem_ack    = 1'b0;
    bus.mem_data_r = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_read || bus.mem_write) begin
        checks++;
        if (bus.mem_read && bus.mem_write) begin
          errors++;
          $display("FAIL strobe_exclusive: mem_read=%b mem_write=%b, required not both 1",
                   bus.mem_read, bus.mem_write);
        end
        if (wait_left < 0) wait_left = next_lat;
        wait_left--;
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          last_addr   = bus.mem_address;
          if (bus.mem_read) begin
            fill_count++;
            for (int w = 0; w < 4; w++)
              bus.mem_data_r[16*w +: 16] = mem_word(bus.mem_address + 16'(w));
          end else begin
            write_count++;
            last_wdata = bus.mem_data_w;
            mem_model[int'(bus.mem_address)] = bus.mem_data_w;
          end
          wait_left = -1;
        end
      end else begin
        wait_left = -1;
        if (inject_ack) begin
          bus.mem_ack = 1'b1;
          inject_ack  = 1'b0;
        end
      end
    end
  end

  // ---------------- request driver ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic run_req(input logic wr, input logic both, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, input logic exp_hit,
                         input string name);
    int cyc;
    int exp_cyc;
    int fills0;
    logic timed_out;
    logic [15:0] exp_d;
    logic [15:0] exp_addr;
    int idx;
    idx    = int'(addr[3:2]);
    fills0 = fill_count;
    next_lat = lat;
    if (!wr) exp_q.push_back(mem_word(addr));
    bus.d_address = addr;
    bus.d_data_w  = wdata;
    bus.d_writeC  = wr;
    bus.d_readC   = !wr || both;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.d_ready === 1'b1) break;
      if (cyc >= 60) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s timeout: no d_ready after %0d cycles, required within %0d", name, cyc, lat + 1);
      if (!wr) void'(exp_q.pop_front());
    end else begin
      exp_cyc = exp_hit ? 0 : lat + 1;
      if (cyc != exp_cyc) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_cyc);
      end
      exp_acc++;
      if (!wr) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (bus.d_data_r !== exp_d) begin
          errors++;
          $display("FAIL %s data: got %h, required %h", name, bus.d_data_r, exp_d);
        end
        checks++;
        if ((fill_count - fills0) != (exp_hit ? 0 : 1)) begin
          errors++;
          $display("FAIL %s fills: got %0d, required %0d", name, fill_count - fills0, exp_hit ? 0 : 1);
        end
        if (exp_hit) exp_hits++;
        else begin
          sh_valid[idx] = 1'b1;
          sh_tag[idx]   = addr[15:4];
        end
      end
      if (!exp_hit) begin
        exp_addr = wr ? addr : {addr[15:2], 2'b00};
        checks++;
        if (last_addr !== exp_addr) begin
          errors++;
          $display("FAIL %s mem_address: got %h, required %h", name, last_addr, exp_addr);
        end
        if (wr) begin
          checks++;
          if (last_wdata !== wdata) begin
            errors++;
            $display("FAIL %s mem_data_w: got %h, required %h", name, last_wdata, wdata);
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.d_readC  = 1'b0;
    bus.d_writeC = 1'b0;
  endtask

  task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
    checks++;
    if (access_count !== 16'(exp_acc)) begin
      errors++;
      $display("FAIL %s access_count: got %0d, required %0d", name, access_count, exp_acc);
    end
    checks++;
    if (hit_count !== 16'(exp_hits)) begin
      errors++;
      $display("FAIL %s hit_count: got %0d, required %0d", name, hit_count, exp_hits);
    end
`else
    if (name.len() == 0) $display("stats not built");
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.d_ready !== 1'b0)      begin errors++; $display("FAIL reset d_ready: got %b, required 0", bus.d_ready); end
    checks++; if (bus.d_data_r !== 16'h0)    begin errors++; $display("FAIL reset d_data_r: got %h, required 0000", bus.d_data_r); end
    checks++; if (bus.mem_read !== 1'b0)     begin errors++; $display("FAIL reset mem_read: got %b, required 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0)    begin errors++; $display("FAIL reset mem_write: got %b, required 0", bus.mem_write); end
    checks++; if (bus.mem_address !== 16'h0) begin errors++; $display("FAIL reset mem_address: got %h, required 0000", bus.mem_address); end
    checks++; if (bus.mem_data_w !== 16'h0)  begin errors++; $display("FAIL reset mem_data_w: got %h, required 0000", bus.mem_data_w); end
    checks++; if (dbg_state !== 2'd0)        begin errors++; $display("FAIL reset state: got %0d, required 0", dbg_state); end
    check_stats("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    // Line at 0x0010 as seen on mem_data_r: 0x4444_3333_2222_1111 (word 0 low).
    mem_model[16'h10] = 16'h1111;
    mem_model[16'h11] = 16'h2222;
    mem_model[16'h12] = 16'h3333;
    mem_model[16'h13] = 16'h4444;
    run_req(1'b0, 1'b0, 16'h0012, 16'h0, 3, 1'b0, "cold_read");
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp_single_cycle d_ready: got %b, required 0", bus.d_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hit_reread();
    run_req(1'b0, 1'b0, 16'h0013, 16'h0, 3, 1'b1, "hit_reread");
  endtask

  task automatic test_write_hit();
    run_req(1'b1, 1'b0, 16'h0011, 16'hBEEF, 2, 1'b0, "write_hit");
    run_req(1'b0, 1'b0, 16'h0011, 16'h0, 2, 1'b1, "read_after_write_hit");
  endtask

  task automatic test_write_miss();
    run_req(1'b1, 1'b0, 16'h0400, 16'h1234, 1, 1'b0, "write_miss");
    run_req(1'b0, 1'b0, 16'h0400, 16'h0, 2, 1'b0, "read_after_write_miss");
  endtask

  task automatic test_conflict();
    run_req(1'b0, 1'b0, 16'h0010, 16'h0, 2, 1'b0, "conflict_a");
    run_req(1'b0, 1'b0, 16'h0050, 16'h0, 3, 1'b0, "conflict_b");
    run_req(1'b0, 1'b0, 16'h0010, 16'h0, 1, 1'b0, "conflict_a_again");
  endtask

  task automatic test_priority();
    // Both strobes on a cached address: the write must win (no same-cycle hit).
    run_req(1'b1, 1'b1, 16'h0011, 16'h5A5A, 2, 1'b0, "both_requests");
    run_req(1'b0, 1'b0, 16'h0011, 16'h0, 2, 1'b1, "read_after_both");
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 1'b0, 16'h0024, 16'h0, 2, 1'b0, "b2b_fill");
    run_req(1'b0, 1'b0, 16'h0027, 16'h0, 2, 1'b1, "b2b_hit_after_resp");
    run_req(1'b1, 1'b0, 16'h0026, 16'h7777, 1, 1'b0, "b2b_write");
    run_req(1'b0, 1'b0, 16'h0026, 16'h0, 1, 1'b1, "b2b_read_written");
  endtask

  task automatic test_random();
    logic wr;
    logic [15:0] addr;
    int idx;
    logic hit;
    for (int n = 0; n < 40; n++) begin
      addr = 16'($urandom_range(0, 2) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      wr   = ($urandom_range(0, 9) < 3);
      idx  = int'(addr[3:2]);
      hit  = !wr && sh_valid[idx] && (sh_tag[idx] == addr[15:4]);
      run_req(wr, 1'b0, addr, 16'($urandom_range(0, 65535)), $urandom_range(1, 4), hit, "random");
    end
    check_stats("random");
  endtask

  task automatic test_reset_mid_fill();
    next_lat = 20;
    bus.d_address = 16'h0090;
    bus.d_readC   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill mem_read: got %b, required 1", bus.mem_read);
    end
    @(negedge clk);
    reset_n     = 1'b0;
    bus.d_readC = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL async_reset mem_read: got %b, required 0", bus.mem_read);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset state: got %0d, required 0", dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) sh_valid[i] = 1'b0;
    exp_acc  = 0;
    exp_hits = 0;
    @(posedge clk); #1;
    inject_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.d_ready !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL stray_ack: d_ready=%b state=%0d, required 0 and 0", bus.d_ready, dbg_state);
      end
    end
    check_stats("after_reset");
    @(posedge clk); #1;
    run_req(1'b0, 1'b0, 16'h0010, 16'h0, 2, 1'b0, "read_after_reset");
  endtask

  initial begin
    bus.d_readC   = 1'b0;
    bus.d_writeC  = 1'b0;
    bus.d_address = '0;
    bus.d_data_w  = '0;
    for (int i = 0; i < 4; i++) begin
      sh_valid[i] = 1'b0;
      sh_tag[i]   = '0;
    end
    test_reset();
    test_cold_read();
    test_hit_reread();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    check_stats("final");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
